// File: rtl/rs_issue_queue.sv
// 16-entry reservation station: CDB wakeup, highest-index free-slot allocation,
// highest-index ready select, and a registered valid/ready issue port.
module rs_issue_queue #(
  parameter int TAG_W = 6,
  parameter int PLD_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [TAG_W-1:0] dispatch_dest_tag,
  input  logic [TAG_W-1:0] dispatch_src1_tag,
  input  logic             dispatch_src1_rdy,
  input  logic [TAG_W-1:0] dispatch_src2_tag,
  input  logic             dispatch_src2_rdy,
  input  logic [PLD_W-1:0] dispatch_payload,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [TAG_W-1:0] issue_dest_tag,
  output logic [TAG_W-1:0] issue_src1_tag,
  output logic [TAG_W-1:0] issue_src2_tag,
  output logic [PLD_W-1:0] issue_payload,
  output logic [4:0]       free_count
);

  localparam int RS_SIZE = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } grant_t;

  // 4-input priority select, highest index wins: {found, idx[1:0]}
  function automatic logic [2:0] ps4(input logic [3:0] req);
    logic [2:0] r;
    if (req[3]) begin
      r = 3'b111;
    end else if (req[2]) begin
      r = 3'b110;
    end else if (req[1]) begin
      r = 3'b101;
    end else if (req[0]) begin
      r = 3'b100;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // Two-level tree of ps4 cells: the top level picks the highest non-empty group
  function automatic grant_t ps16(input logic [15:0] req, input logic en);
    logic [2:0] grp [4];
    logic [2:0] top;
    grant_t     g;
    for (int k = 0; k < 4; k++) begin
      grp[k] = ps4(req[k*4 +: 4]);
    end
    top     = ps4({grp[3][2], grp[2][2], grp[1][2], grp[0][2]});
    g.found = en & top[2];
    g.idx   = {top[1:0], grp[top[1:0]][1:0]};
    return g;
  endfunction

  logic [RS_SIZE-1:0] valid_r;
  logic [RS_SIZE-1:0] src1_rdy_r;
  logic [RS_SIZE-1:0] src2_rdy_r;
  logic [TAG_W-1:0]   dest_tag_r [RS_SIZE];
  logic [TAG_W-1:0]   src1_tag_r [RS_SIZE];
  logic [TAG_W-1:0]   src2_tag_r [RS_SIZE];
  logic [PLD_W-1:0]   payload_r  [RS_SIZE];

  logic               issue_valid_r;
  logic [TAG_W-1:0]   issue_dest_r;
  logic [TAG_W-1:0]   issue_src1_r;
  logic [TAG_W-1:0]   issue_src2_r;
  logic [PLD_W-1:0]   issue_payload_r;
  logic [4:0]         free_count_r;
  logic               dispatch_ready_r;

  logic [RS_SIZE-1:0] ready_vec_s;
  logic               load_issue_s;
  grant_t             alloc_s;
  grant_t             sel_s;
  logic               do_dispatch_s;
  logic               byp1_s;
  logic               byp2_s;
  logic [4:0]         free_next_s;

  // Allocation/select grants and the same-cycle CDB bypass for dispatch
  always_comb begin
    ready_vec_s   = valid_r & src1_rdy_r & src2_rdy_r;
    load_issue_s  = !issue_valid_r | issue_ready;
    alloc_s       = ps16(~valid_r, 1'b1);
    sel_s         = ps16(ready_vec_s, load_issue_s);
    do_dispatch_s = dispatch_valid & dispatch_ready_r & alloc_s.found;
    byp1_s        = dispatch_src1_rdy | (cdb_valid & (cdb_tag == dispatch_src1_tag));
    byp2_s        = dispatch_src2_rdy | (cdb_valid & (cdb_tag == dispatch_src2_tag));
    free_next_s   = free_count_r - {4'd0, do_dispatch_s} + {4'd0, sel_s.found};
  end

  // Entry control bits: allocate, wake, and invalidate on select
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      valid_r    <= {RS_SIZE{1'b0}};
      src1_rdy_r <= {RS_SIZE{1'b0}};
      src2_rdy_r <= {RS_SIZE{1'b0}};
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        // Allocation only targets a free slot, so it never collides with select or wakeup
        if (do_dispatch_s && (alloc_s.idx == 4'(i))) begin
          valid_r[i]    <= 1'b1;
          src1_rdy_r[i] <= byp1_s;
          src2_rdy_r[i] <= byp2_s;
        end else begin
          if (sel_s.found && (sel_s.idx == 4'(i))) begin
            valid_r[i] <= 1'b0;
          end
          if (cdb_valid && valid_r[i] && (src1_tag_r[i] == cdb_tag)) begin
            src1_rdy_r[i] <= 1'b1;
          end
          if (cdb_valid && valid_r[i] && (src2_tag_r[i] == cdb_tag)) begin
            src2_rdy_r[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Entry data fields; contents of invalid slots are don't-care
  always_ff @(posedge clock) begin
    if (do_dispatch_s && !reset && !squash) begin
      dest_tag_r[alloc_s.idx] <= dispatch_dest_tag;
      src1_tag_r[alloc_s.idx] <= dispatch_src1_tag;
      src2_tag_r[alloc_s.idx] <= dispatch_src2_tag;
      payload_r[alloc_s.idx]  <= dispatch_payload;
    end
  end

  // Issue register: loads the granted entry whenever the port can take one
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      issue_valid_r   <= 1'b0;
      issue_dest_r    <= {TAG_W{1'b0}};
      issue_src1_r    <= {TAG_W{1'b0}};
      issue_src2_r    <= {TAG_W{1'b0}};
      issue_payload_r <= {PLD_W{1'b0}};
    end else if (load_issue_s) begin
      if (sel_s.found) begin
        issue_valid_r   <= 1'b1;
        issue_dest_r    <= dest_tag_r[sel_s.idx];
        issue_src1_r    <= src1_tag_r[sel_s.idx];
        issue_src2_r    <= src2_tag_r[sel_s.idx];
        issue_payload_r <= payload_r[sel_s.idx];
      end else begin
        issue_valid_r <= 1'b0;
      end
    end
  end

  // Free-slot bookkeeping kept in registers so dispatch_ready reflects start-of-cycle state
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      free_count_r     <= 5'd16;
      dispatch_ready_r <= 1'b1;
    end else begin
      free_count_r     <= free_next_s;
      dispatch_ready_r <= (free_next_s != 5'd0);
    end
  end

  assign dispatch_ready = dispatch_ready_r;
  assign free_count     = free_count_r;
  assign issue_valid    = issue_valid_r;
  assign issue_dest_tag = issue_dest_r;
  assign issue_src1_tag = issue_src1_r;
  assign issue_src2_tag = issue_src2_r;
  assign issue_payload  = issue_payload_r;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Bench for rs_issue_queue: directed scenarios plus random traffic, all checked
// against a per-cycle array model of the reservation station.
module tb_rs_issue_queue;

  logic        clock = 1'b0;
  logic        reset, squash;
  logic        dispatch_valid, dispatch_ready;
  logic [5:0]  dispatch_dest_tag, dispatch_src1_tag, dispatch_src2_tag;
  logic        dispatch_src1_rdy, dispatch_src2_rdy;
  logic [31:0] dispatch_payload;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic        issue_valid, issue_ready;
  logic [5:0]  issue_dest_tag, issue_src1_tag, issue_src2_tag;
  logic [31:0] issue_payload;
  logic [4:0]  free_count;

  int n_checks = 0;
  int n_errors = 0;

  rs_issue_queue #(.TAG_W(6), .PLD_W(32)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_dest_tag(dispatch_dest_tag),
    .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src1_rdy(dispatch_src1_rdy),
    .dispatch_src2_tag(dispatch_src2_tag), .dispatch_src2_rdy(dispatch_src2_rdy),
    .dispatch_payload(dispatch_payload),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_dest_tag(issue_dest_tag), .issue_src1_tag(issue_src1_tag),
    .issue_src2_tag(issue_src2_tag), .issue_payload(issue_payload),
    .free_count(free_count)
  );

  always #5 clock = ~clock;

  // Reference model: one record per slot plus the issue register
  logic        m_valid [16];
  logic        m_r1 [16];
  logic        m_r2 [16];
  logic [5:0]  m_dest [16];
  logic [5:0]  m_s1 [16];
  logic [5:0]  m_s2 [16];
  logic [31:0] m_pld [16];
  logic        m_iv;
  logic [5:0]  m_idest, m_is1, m_is2;
  logic [31:0] m_ipld;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < 16; i++) if (!m_valid[i]) n++;
    return n;
  endfunction

  task automatic model_step();
    int  sel = -1;
    int  alloc = -1;
    logic load;
    if (reset || squash) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_iv = 1'b0; m_idest = 6'd0; m_is1 = 6'd0; m_is2 = 6'd0; m_ipld = 32'd0;
      return;
    end
    load = !m_iv || issue_ready;
    if (load)
      for (int i = 15; i >= 0; i--)
        if (sel < 0 && m_valid[i] && m_r1[i] && m_r2[i]) sel = i;
    if (dispatch_valid && m_free() > 0)
      for (int i = 15; i >= 0; i--)
        if (alloc < 0 && !m_valid[i]) alloc = i;
    if (load) begin
      if (sel >= 0) begin
        m_iv = 1'b1; m_idest = m_dest[sel]; m_is1 = m_s1[sel];
        m_is2 = m_s2[sel]; m_ipld = m_pld[sel]; m_valid[sel] = 1'b0;
      end else begin
        m_iv = 1'b0;
      end
    end
    if (cdb_valid)
      for (int i = 0; i < 16; i++)
        if (m_valid[i]) begin
          if (m_s1[i] == cdb_tag) m_r1[i] = 1'b1;
          if (m_s2[i] == cdb_tag) m_r2[i] = 1'b1;
        end
    if (alloc >= 0) begin
      m_valid[alloc] = 1'b1;
      m_dest[alloc] = dispatch_dest_tag; m_s1[alloc] = dispatch_src1_tag;
      m_s2[alloc] = dispatch_src2_tag; m_pld[alloc] = dispatch_payload;
      m_r1[alloc] = dispatch_src1_rdy || (cdb_valid && cdb_tag == dispatch_src1_tag);
      m_r2[alloc] = dispatch_src2_rdy || (cdb_valid && cdb_tag == dispatch_src2_tag);
    end
  endtask

  task automatic compare_all();
    check("issue_valid", 64'(issue_valid), 64'(m_iv));
    if (m_iv) begin
      check("issue_dest", 64'(issue_dest_tag), 64'(m_idest));
      check("issue_src1", 64'(issue_src1_tag), 64'(m_is1));
      check("issue_src2", 64'(issue_src2_tag), 64'(m_is2));
      check("issue_payload", 64'(issue_payload), 64'(m_ipld));
    end
    check("free_count", 64'(free_count), 64'(m_free()));
    check("dispatch_ready", 64'(dispatch_ready), 64'(m_free() > 0));
  endtask

  // Inputs are set at the falling edge; one call covers one rising edge
  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle();
    reset = 1'b0; squash = 1'b0; dispatch_valid = 1'b0; cdb_valid = 1'b0;
    cdb_tag = 6'd0; issue_ready = 1'b1;
    dispatch_dest_tag = 6'd0; dispatch_src1_tag = 6'd0; dispatch_src2_tag = 6'd0;
    dispatch_src1_rdy = 1'b0; dispatch_src2_rdy = 1'b0; dispatch_payload = 32'd0;
  endtask

  task automatic disp(input logic [5:0] s1, input logic r1, input logic [5:0] s2,
                      input logic r2, input logic [31:0] pld);
    dispatch_valid = 1'b1; dispatch_dest_tag = pld[5:0] ^ 6'd32;
    dispatch_src1_tag = s1; dispatch_src1_rdy = r1;
    dispatch_src2_tag = s2; dispatch_src2_rdy = r2; dispatch_payload = pld;
  endtask

  initial begin
    int dprob;
    idle();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0;
      m_dest[i] = 6'd0; m_s1[i] = 6'd0; m_s2[i] = 6'd0; m_pld[i] = 32'd0;
    end
    m_iv = 1'b0; m_idest = 6'd0; m_is1 = 6'd0; m_is2 = 6'd0; m_ipld = 32'd0;
    @(negedge clock);
    reset = 1'b1; step(); step();
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_tags", 64'({issue_dest_tag, issue_src1_tag, issue_src2_tag}), 64'd0);
    check("rst_issue_payload", 64'(issue_payload), 64'd0);
    check("rst_free_count", 64'(free_count), 64'd16);
    check("rst_dispatch_ready", 64'(dispatch_ready), 64'd1);
    reset = 1'b0;

    // Both sources ready at dispatch: visible on the issue port two edges later
    disp(6'd3, 1'b1, 6'd4, 1'b1, 32'hA0); step(); idle();
    check("lat_free_15", 64'(free_count), 64'd15);
    check("lat_not_yet", 64'(issue_valid), 64'd0);
    step();
    check("lat_issue_valid", 64'(issue_valid), 64'd1);
    check("lat_payload", 64'(issue_payload), 64'hA0);
    check("lat_free_16", 64'(free_count), 64'd16);
    step();
    check("drain_empty", 64'(issue_valid), 64'd0);

    // Fill all 16 slots with unready entries; the 17th dispatch is ignored
    for (int k = 0; k < 16; k++) begin
      disp(6'd60, 1'b0, 6'd61, 1'b0, 32'(100 + k)); step();
    end
    check("full_ready", 64'(dispatch_ready), 64'd0);
    check("full_count", 64'(free_count), 64'd0);
    disp(6'd1, 1'b1, 6'd1, 1'b1, 32'hDEAD); step();
    check("full_ignored", 64'(free_count), 64'd0);
    check("full_no_issue", 64'(issue_valid), 64'd0);
    idle(); squash = 1'b1; step(); idle();

    // Entries 9 and 2 wait on tag 7; payload carries the slot index
    for (int k = 0; k < 16; k++) begin
      disp(((15 - k) == 9 || (15 - k) == 2) ? 6'd7 : 6'd60, 1'b0, 6'd62,
           ((15 - k) == 9 || (15 - k) == 2), 32'(15 - k));
      step();
    end
    idle(); cdb_valid = 1'b1; cdb_tag = 6'd7; step(); idle();
    step();
    check("wake_first_valid", 64'(issue_valid), 64'd1);
    check("wake_first_entry9", 64'(issue_payload), 64'd9);
    step();
    check("wake_second_entry2", 64'(issue_payload), 64'd2);
    squash = 1'b1; step(); idle();

    // Dispatch-time bypass from a same-cycle CDB broadcast
    disp(6'd5, 1'b0, 6'd6, 1'b1, 32'h55AA); cdb_valid = 1'b1; cdb_tag = 6'd5; step(); idle();
    step();
    check("bypass_issue", 64'(issue_valid), 64'd1);
    check("bypass_payload", 64'(issue_payload), 64'h55AA);
    step();

    // Stall with two ready entries: held outputs, only the first slot freed
    issue_ready = 1'b0; disp(6'd1, 1'b1, 6'd2, 1'b1, 32'h55); step();
    disp(6'd1, 1'b1, 6'd2, 1'b1, 32'h66); step(); dispatch_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_payload", 64'(issue_payload), 64'h55);
      check("stall_free", 64'(free_count), 64'd15);
    end

    // Squash with five entries and a stalled issue; same-cycle dispatch dropped
    for (int k = 0; k < 4; k++) begin
      disp(6'd40, 1'b0, 6'd41, 1'b0, 32'(200 + k)); step();
    end
    check("pre_squash_free", 64'(free_count), 64'd11);
    disp(6'd1, 1'b1, 6'd1, 1'b1, 32'h77); squash = 1'b1; step(); idle();
    check("squash_issue", 64'(issue_valid), 64'd0);
    check("squash_free", 64'(free_count), 64'd16);
    step();
    check("squash_dropped", 64'(issue_valid), 64'd0);

    // Random traffic in phases of heavier and lighter dispatch pressure
    for (int c = 0; c < 4000; c++) begin
      dprob = ((c / 500) % 2 == 0) ? 85 : 35;
      reset  = ($urandom_range(0, 999) == 0);
      squash = ($urandom_range(0, 99) == 0);
      dispatch_valid    = ($urandom_range(0, 99) < dprob);
      dispatch_dest_tag = 6'($urandom_range(0, 63));
      dispatch_src1_tag = 6'($urandom_range(0, 15));
      dispatch_src2_tag = 6'($urandom_range(0, 15));
      dispatch_src1_rdy = ($urandom_range(0, 3) == 0);
      dispatch_src2_rdy = ($urandom_range(0, 3) == 0);
      dispatch_payload  = $urandom;
      cdb_valid   = ($urandom_range(0, 1) == 1);
      cdb_tag     = 6'($urandom_range(0, 15));
      issue_ready = ($urandom_range(0, 99) < 55);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
